vga_text_renderer: RTL
======================

Name: vga_text_renderer

Overview:
- Parametrised text-mode pixel pipeline: turns hcount/vcount from the VGA timing generator into RGB.
- Looks up character, colour and glyph memories, all internal and on one clock.
- Adds features the first-generation text path lacks:
  - configurable grid and glyph size;
  - 16-entry writable palette;
  - hardware scroll (circular row base);
  - blinking underline cursor.
- Sits between vga_block and the VGA pins. The host drives its memory ports via the APB front-end.

Parameters:
COLS, 80, text columns
ROWS, 30, text rows
GLYPH_W, 8, glyph width in pixels
GLYPH_H, 16, glyph height in pixels
CH_COUNT, 256, number of glyphs (power of 2)
COLOR_W, 4, bits per RGB channel
BLINK_FRAMES, 32, frames per cursor blink half-period (>=1)

Ports:
clk_i  in  1  pixel clock, all logic on rising edge
arstn_i  in  1  asynchronous active-low reset
hcount_i  in  $clog2(COLS*GLYPH_W)  pixel x from timing generator
vcount_i  in  $clog2(ROWS*GLYPH_H)  pixel y
pixel_enable_i  in  1  visible-area flag
hs_i, vs_i  in  1 each  syncs from timing generator (vs_i active-low)
ch_addr_i  in  $clog2(COLS*ROWS)  host char-map address
ch_we_i, ch_wdata_i[$clog2(CH_COUNT)], ch_rdata_o  host char-map port
col_addr_i, col_we_i, col_wdata_i[8], col_rdata_o[8]  host colour-map port; byte = {fg[7:4], bg[3:0]}
gl_addr_i[$clog2(CH_COUNT)], gl_we_i, gl_wdata_i[GLYPH_W*GLYPH_H], gl_rdata_o  host glyph port
pal_addr_i[4], pal_we_i, pal_wdata_i[3*COLOR_W]  palette write; {R,G,B}
cursor_en_i  in  1  cursor enable
cursor_x_i, cursor_y_i  in  column/row widths  cursor cell in screen coordinates
scroll_row_i  in  $clog2(ROWS)  memory row shown on screen row 0
r_o, g_o, b_o  out  COLOR_W each  pixel colour
hs_o, vs_o  out  1 each  delayed syncs

Behaviour:
- Reset (arstn_i low, async):
  - All pipeline registers clear: r_o/g_o/b_o = 0, hs_o = vs_o = 0.
  - Blink counter = 0, blink phase = on, latched scroll = 0.
  - Palette entry i = {i,i,i} truncated/zero-extended to COLOR_W.
  - Memory contents are not reset.
- Pipeline: fixed latency of 4 clocks from hcount_i/vcount_i/pixel_enable_i/hs_i/vs_i to r_o/g_o/b_o/hs_o/vs_o. hs/vs/enable are delayed through matching registers.
  - S1: compute cell col = hcount/GLYPH_W, screen row = vcount/GLYPH_H, gx, gy. Memory row = (row + scroll_latched) mod ROWS, with no out-of-range index. Register the cell address.
  - S2: char-map and colour-map synchronous reads.
  - S3: glyph read indexed by the char code.
  - S4: select bit gy*GLYPH_W+gx (1 = foreground), apply cursor, look up palette, register outputs.
- Outputs are 0 when the delayed enable is low, or the pixel lies outside COLS*GLYPH_W × ROWS*GLYPH_H.
- Scroll: scroll_row_i is latched on each vs_i falling edge only, so no mid-frame tearing. Values >= ROWS are latched as 0.
- Cursor: drawn when all of the following hold:
  - cursor_en_i is high;
  - blink phase is on;
  - the screen cell equals (cursor_x_i, cursor_y_i);
  - gy >= GLYPH_H-2.

  The selected pixel then shows fg regardless of glyph bit. Cursor coordinates are compared in screen space, after scroll.
- Blink:
  - Counter increments on each vs_i falling edge.
  - At BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - Deasserting cursor_en_i does not reset the counter.
- Host ports:
  - 1-cycle read latency, read-first: a same-cycle write to the same address returns old data.
  - Char/colour addresses >= COLS*ROWS: writes ignored, rdata = 0.
  - A host write to any memory and a render read of the same location in the same cycle: the renderer sees old data.
- Palette write takes effect from the next clock.
- If pal_we_i and a render lookup hit the same entry in the same cycle, the render uses the old value.

Test Plan:
- Write char 0x41 at addr 0, glyph 0x41 all-ones, colour 0xF0, palette[15] = 0xFFF; drive hcount=0, vcount=0, enable=1 → r/g/b = 0xF exactly 4 clocks later; hs_o/vs_o equal to hs_i/vs_i delayed by 4.
- Pull arstn_i low mid-line → outputs 0 immediately (async), palette[5] reads back as gray 5 through render.
- scroll_row_i = 29 changed mid-frame → screen row 0 shows memory row 0 until the next vs_i falling edge, then memory row 29; row 1 then shows memory row 0 (wrap).
- Cursor at (3,2), BLINK_FRAMES = 2 → underline on pixel rows 46–47 of cell for frames 0–1, absent in frames 2–3, back on in frame 4.
- Host write and read of ch addr 100 in the same cycle → rdata is old value, next read returns new; write to addr 2400 → ignored, rdata 0.
- hcount beyond 639 with enable forced high → outputs 0.

Source files
------------

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: maps timing-generator coordinates to RGB through
// char/colour/glyph memories, a writable palette, hardware scroll and a blinking cursor.
module vga_text_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int CH_COUNT     = 256,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                                clk_i,
  input  logic                                arstn_i,
  input  logic [$clog2(COLS*GLYPH_W)-1:0]     hcount_i,
  input  logic [$clog2(ROWS*GLYPH_H)-1:0]     vcount_i,
  input  logic                                pixel_enable_i,
  input  logic                                hs_i,
  input  logic                                vs_i,
  input  logic [$clog2(COLS*ROWS)-1:0]        ch_addr_i,
  input  logic                                ch_we_i,
  input  logic [$clog2(CH_COUNT)-1:0]         ch_wdata_i,
  output logic [$clog2(CH_COUNT)-1:0]         ch_rdata_o,
  input  logic [$clog2(COLS*ROWS)-1:0]        col_addr_i,
  input  logic                                col_we_i,
  input  logic [7:0]                          col_wdata_i,
  output logic [7:0]                          col_rdata_o,
  input  logic [$clog2(CH_COUNT)-1:0]         gl_addr_i,
  input  logic                                gl_we_i,
  input  logic [GLYPH_W*GLYPH_H-1:0]          gl_wdata_i,
  output logic [GLYPH_W*GLYPH_H-1:0]          gl_rdata_o,
  input  logic [3:0]                          pal_addr_i,
  input  logic                                pal_we_i,
  input  logic [3*COLOR_W-1:0]                pal_wdata_i,
  input  logic                                cursor_en_i,
  input  logic [$clog2(COLS)-1:0]             cursor_x_i,
  input  logic [$clog2(ROWS)-1:0]             cursor_y_i,
  input  logic [$clog2(ROWS)-1:0]             scroll_row_i,
  output logic [COLOR_W-1:0]                  r_o,
  output logic [COLOR_W-1:0]                  g_o,
  output logic [COLOR_W-1:0]                  b_o,
  output logic                                hs_o,
  output logic                                vs_o
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(CH_COUNT);
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int GB    = GLYPH_W * GLYPH_H;
  localparam int BIW   = (GB > 1) ? $clog2(GB) : 1;
  localparam int GXW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int GYW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PW    = 3 * COLOR_W;

  logic [CW-1:0] ch_mem  [CELLS];
  logic [7:0]    col_mem [CELLS];
  logic [GB-1:0] gl_mem  [CH_COUNT];
  logic [PW-1:0] pal     [16];

  // ---------------- host ports ----------------
  logic ch_ok, col_ok;
  assign ch_ok  = (32'(ch_addr_i)  < CELLS);
  assign col_ok = (32'(col_addr_i) < CELLS);

  always_ff @(posedge clk_i) begin
    if (ch_we_i && ch_ok) ch_mem[ch_addr_i] <= ch_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (col_we_i && col_ok) col_mem[col_addr_i] <= col_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (gl_we_i) gl_mem[gl_addr_i] <= gl_wdata_i;
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ch_rdata_o  <= '0;
      col_rdata_o <= '0;
      gl_rdata_o  <= '0;
    end else begin
      ch_rdata_o  <= ch_ok  ? ch_mem[ch_addr_i]   : '0;
      col_rdata_o <= col_ok ? col_mem[col_addr_i] : '0;
      gl_rdata_o  <= gl_mem[gl_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= {COLOR_W'(i), COLOR_W'(i), COLOR_W'(i)};
      end
    end else if (pal_we_i) begin
      pal[pal_addr_i] <= pal_wdata_i;
    end
  end

  // ---------------- frame-rate state ----------------
  logic          vs_prev;
  logic          vs_fall;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [YW-1:0] scroll_q;

  assign vs_fall = vs_prev & ~vs_i;

  // Scroll is only sampled at frame start so a frame never shows two bases.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vs_prev   <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      scroll_q  <= '0;
    end else begin
      vs_prev <= vs_i;
      if (vs_fall) begin
        scroll_q <= (32'(scroll_row_i) < ROWS) ? scroll_row_i : '0;
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- S1: cell decode ----------------
  int unsigned    col_n, row_n, mrow_n;
  logic           in_n;
  logic [GXW-1:0] gx_n;
  logic [GYW-1:0] gy_n;
  logic [AW-1:0]  addr_n;
  logic           cur_n;
  logic [BIW-1:0] bit_n;

  always_comb begin
    col_n  = 32'(hcount_i) / GLYPH_W;
    row_n  = 32'(vcount_i) / GLYPH_H;
    gx_n   = GXW'(32'(hcount_i) % GLYPH_W);
    gy_n   = GYW'(32'(vcount_i) % GLYPH_H);
    in_n   = (col_n < COLS) && (row_n < ROWS);
    mrow_n = row_n + 32'(scroll_q);
    if (mrow_n >= ROWS) mrow_n = mrow_n - ROWS;
    addr_n = in_n ? AW'(mrow_n * COLS + col_n) : '0;
    // Cursor matches in screen space, i.e. before the scroll offset is applied.
    cur_n  = in_n && (XW'(col_n) == cursor_x_i) && (YW'(row_n) == cursor_y_i) &&
             (32'(gy_n) + 2 >= GLYPH_H);
    bit_n  = BIW'(32'(gy_n) * GLYPH_W + 32'(gx_n));
  end

  logic [AW-1:0]  addr_s1;
  logic [BIW-1:0] bit_s1, bit_s2, bit_s3;
  logic           cur_s1, cur_s2, cur_s3;
  logic           vis_s1, vis_s2, vis_s3;
  logic [CW-1:0]  ch_s2;
  logic [7:0]     colr_s2, colr_s3;
  logic [GB-1:0]  glyph_s3;
  logic [3:0]     hs_pipe, vs_pipe;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      addr_s1  <= '0;
      bit_s1   <= '0;
      cur_s1   <= 1'b0;
      vis_s1   <= 1'b0;
      ch_s2    <= '0;
      colr_s2  <= '0;
      bit_s2   <= '0;
      cur_s2   <= 1'b0;
      vis_s2   <= 1'b0;
      glyph_s3 <= '0;
      colr_s3  <= '0;
      bit_s3   <= '0;
      cur_s3   <= 1'b0;
      vis_s3   <= 1'b0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      addr_s1  <= addr_n;
      bit_s1   <= bit_n;
      cur_s1   <= cur_n;
      vis_s1   <= pixel_enable_i & in_n;
      ch_s2    <= ch_mem[addr_s1];
      colr_s2  <= col_mem[addr_s1];
      bit_s2   <= bit_s1;
      cur_s2   <= cur_s1;
      vis_s2   <= vis_s1;
      glyph_s3 <= gl_mem[ch_s2];
      colr_s3  <= colr_s2;
      bit_s3   <= bit_s2;
      cur_s3   <= cur_s2;
      vis_s3   <= vis_s2;
      hs_pipe  <= {hs_pipe[2:0], hs_i};
      vs_pipe  <= {vs_pipe[2:0], vs_i};
    end
  end

  assign hs_o = hs_pipe[3];
  assign vs_o = vs_pipe[3];

  // ---------------- S4: pixel select and palette ----------------
  logic          pix_fg;
  logic [3:0]    pal_idx;
  logic [PW-1:0] rgb_n;

  always_comb begin
    pix_fg  = glyph_s3[bit_s3] | (cur_s3 & cursor_en_i & blink_on);
    pal_idx = pix_fg ? colr_s3[7:4] : colr_s3[3:0];
    rgb_n   = vis_s3 ? pal[pal_idx] : '0;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else begin
      {r_o, g_o, b_o} <= rgb_n;
    end
  end

endmodule
